// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Build option: DMEM_ARB_RR_EN selects round-robin grant.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_BE_W   = 4;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DBG = 1'b1
  } port_e;

  typedef struct packed {
    logic                   we;
    logic [DMEM_BE_W-1:0]   be;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

  typedef struct packed {
    logic  pend;
    port_e port;
    logic  we;
  } rsp_tag_t;

  localparam dmem_req_t REQ_IDLE = '0;

  function automatic logic [DMEM_BE_W-1:0] write_strobes(
    input dmem_req_t req
  );
    return req.we ? req.be : '0;
  endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// One-hot grant for the two memory requesters.
// DMEM_ARB_RR_EN: strict round-robin; otherwise fixed priority with starvation guard.
module dmem_arb_grant
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       v0,
  input  logic       v1,
  output logic [1:0] gnt
);

`ifdef DMEM_ARB_RR_EN

  port_e rr_ptr;
  logic  pick1;

  assign pick1 = v1 && (!v0 || rr_ptr == PORT_DBG);

  always_comb begin
    gnt    = 2'b00;
    gnt[1] = rst_n && pick1;
    gnt[0] = rst_n && v0 && !pick1;
  end

  // Whoever wins hands preference to the other port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= PORT_CPU;
    end else if (gnt[0]) begin
      rr_ptr <= PORT_DBG;
    end else if (gnt[1]) begin
      rr_ptr <= PORT_CPU;
    end
  end

`else

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             pick1;

  assign starved = (starve_cnt == LIMIT);
  assign pick1   = v1 && (!v0 || starved);

  always_comb begin
    gnt    = 2'b00;
    gnt[1] = rst_n && pick1;
    gnt[0] = rst_n && v0 && !pick1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (v1 && !gnt[1]) begin
      if (!starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end

`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port 256x32 data memory.
// DMEM_ARB_RR_EN switches the grant policy to round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   p0_valid,
  output logic                   p0_ready,
  input  logic                   p0_we,
  input  logic [DMEM_BE_W-1:0]   p0_be,
  input  logic [DMEM_ADDR_W-1:0] p0_addr,
  input  logic [DMEM_DATA_W-1:0] p0_wdata,
  output logic                   p0_rsp_valid,
  output logic [DMEM_DATA_W-1:0] p0_rsp_rdata,
  input  logic                   p1_valid,
  output logic                   p1_ready,
  input  logic                   p1_we,
  input  logic [DMEM_BE_W-1:0]   p1_be,
  input  logic [DMEM_ADDR_W-1:0] p1_addr,
  input  logic [DMEM_DATA_W-1:0] p1_wdata,
  output logic                   p1_rsp_valid,
  output logic [DMEM_DATA_W-1:0] p1_rsp_rdata,
  output logic [DMEM_BE_W-1:0]   mem_writeb,
  output logic                   mem_read,
  output logic [DMEM_ADDR_W-1:0] mem_addr,
  output logic [DMEM_DATA_W-1:0] mem_wdata,
  input  logic [DMEM_DATA_W-1:0] mem_rdata
);

  logic [1:0] gnt;
  logic       accept;
  dmem_req_t  req0;
  dmem_req_t  req1;
  dmem_req_t  sel;
  rsp_tag_t   tag;
  logic       rsp_live;
  logic [DMEM_DATA_W-1:0] rsp_data;

  dmem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_grant (
    .clk  (clk),
    .rst_n(rst_n),
    .v0   (p0_valid),
    .v1   (p1_valid),
    .gnt  (gnt)
  );

  assign p0_ready = gnt[0];
  assign p1_ready = gnt[1];
  assign accept   = |gnt;

  assign req0 = '{we: p0_we, be: p0_be,
                  addr: p0_addr, wdata: p0_wdata};
  assign req1 = '{we: p1_we, be: p1_be,
                  addr: p1_addr, wdata: p1_wdata};

  // Idle cycles drive an all-zero request onto the memory.
  always_comb begin
    sel = REQ_IDLE;
    unique case (1'b1)
      gnt[0]:  sel = req0;
      gnt[1]:  sel = req1;
      default: sel = REQ_IDLE;
    endcase
  end

  assign mem_addr   = sel.addr;
  assign mem_wdata  = sel.wdata;
  assign mem_writeb = write_strobes(sel);
  assign mem_read   = accept && !sel.we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag <= '0;
    end else begin
      tag.pend <= accept;
      tag.port <= gnt[1] ? PORT_DBG : PORT_CPU;
      tag.we   <= sel.we;
    end
  end

  // A response left over from before reset must never surface.
  assign rsp_live = tag.pend && rst_n;
  assign rsp_data = tag.we ? '0 : mem_rdata;

  always_comb begin
    p0_rsp_valid = 1'b0;
    p1_rsp_valid = 1'b0;
    p0_rsp_rdata = '0;
    p1_rsp_rdata = '0;
    if (rsp_live) begin
      unique case (tag.port)
        PORT_CPU: begin
          p0_rsp_valid = 1'b1;
          p0_rsp_rdata = rsp_data;
        end
        PORT_DBG: begin
          p1_rsp_valid = 1'b1;
          p1_rsp_rdata = rsp_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural memory model.
// Define DMEM_ARB_RR_EN to check the round-robin build.
module tb_dmem_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_valid, p1_valid;
  logic        p0_ready, p1_ready;
  logic        p0_we, p1_we;
  logic [3:0]  p0_be, p1_be;
  logic [7:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_rsp_valid, p1_rsp_valid;
  logic [31:0] p0_rsp_rdata, p1_rsp_rdata;
  logic [3:0]  mem_writeb;
  logic        mem_read;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_ready(p0_ready),
    .p0_we(p0_we), .p0_be(p0_be),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_valid(p1_valid), .p1_ready(p1_ready),
    .p1_we(p1_we), .p1_be(p1_be),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
    .mem_writeb(mem_writeb), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory device: byte writes and registered read on the same edge.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_writeb[b])
        ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (mem_read) mem_rdata <= ram[mem_addr];
  end

  // Reference model state
  int          m_wait;
  bit          m_pref1;
  logic [31:0] ref_mem [256];
  bit          pend_v, pend_port;
  logic [31:0] pend_data;

  bit          exp_g0, exp_g1, exp_rd, exp_rv0, exp_rv1;
  logic [3:0]  exp_wb;
  logic [7:0]  exp_addr;
  logic [31:0] exp_wdata, exp_rd0, exp_rd1;

  task automatic predict();
    bit favour1;
    bit w;
    logic [3:0] be;
`ifdef DMEM_ARB_RR_EN
    favour1 = m_pref1;
`else
    favour1 = (m_wait >= STARVE_LIMIT);
`endif
    exp_g1 = rst_n && p1_valid && (!p0_valid || favour1);
    exp_g0 = rst_n && p0_valid && !exp_g1;
    w = exp_g0 ? p0_we : p1_we;
    be = exp_g0 ? p0_be : p1_be;
    exp_addr  = exp_g0 ? p0_addr : (exp_g1 ? p1_addr : 8'h0);
    exp_wdata = exp_g0 ? p0_wdata : (exp_g1 ? p1_wdata : 32'h0);
    exp_wb = ((exp_g0 || exp_g1) && w) ? be : 4'h0;
    exp_rd = (exp_g0 || exp_g1) && !w;
    exp_rv0 = rst_n && pend_v && !pend_port;
    exp_rv1 = rst_n && pend_v && pend_port;
    exp_rd0 = exp_rv0 ? pend_data : 32'h0;
    exp_rd1 = exp_rv1 ? pend_data : 32'h0;
  endtask

  task automatic commit();
    bit w;
    logic [3:0] be;
    logic [7:0] a;
    logic [31:0] d;
    if (!rst_n) begin
      m_wait = 0;
      m_pref1 = 0;
      pend_v = 0;
    end else begin
      w  = exp_g0 ? p0_we : p1_we;
      be = exp_g0 ? p0_be : p1_be;
      a  = exp_g0 ? p0_addr : p1_addr;
      d  = exp_g0 ? p0_wdata : p1_wdata;
      pend_v = exp_g0 || exp_g1;
      pend_port = exp_g1;
      pend_data = w ? 32'h0 : ref_mem[a];
      if (pend_v && w)
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      if (p1_valid && !exp_g1)
        m_wait = (m_wait < STARVE_LIMIT) ? m_wait + 1 : m_wait;
      else
        m_wait = 0;
      if (exp_g0) m_pref1 = 1;
      else if (exp_g1) m_pref1 = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic set_p0(bit v, bit we, logic [3:0] be,
                        logic [7:0] a, logic [31:0] d);
    p0_valid = v; p0_we = we; p0_be = be;
    p0_addr = a; p0_wdata = d;
  endtask

  task automatic set_p1(bit v, bit we, logic [3:0] be,
                        logic [7:0] a, logic [31:0] d);
    p1_valid = v; p1_we = we; p1_be = be;
    p1_addr = a; p1_wdata = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_p0(1, 1, 4'hF, 8'h01, 32'h1);
    set_p1(1, 0, 4'h0, 8'h02, 32'h2);
    predict();
    @(negedge clk);
    n_checks++;
    if ({p0_ready, p1_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready got %b want 00",
               {p0_ready, p1_ready});
    end
    n_checks++;
    if ({mem_writeb, mem_read} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_strobes got %b want 0",
               {mem_writeb, mem_read});
    end
    n_checks++;
    if ({p0_rsp_valid, p1_rsp_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_rsp got %b want 00",
               {p0_rsp_valid, p1_rsp_valid});
    end
    step();
    rst_n = 1'b1;
    set_p0(0, 0, 4'h0, 8'h0, 32'h0);
    set_p1(0, 0, 4'h0, 8'h0, 32'h0);
    predict();
    step();
  endtask

  task automatic test_write_read();
    set_p0(1, 1, 4'hF, 8'h10, 32'hDEADBEEF);
    predict();
    @(negedge clk);
    n_checks++;
    if ({p0_ready, mem_writeb, mem_read, mem_addr, mem_wdata}
        !== {1'b1, 4'hF, 1'b0, 8'h10, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL wr_drive got %b %h %b %h %h", p0_ready,
               mem_writeb, mem_read, mem_addr, mem_wdata);
    end
    step();
    set_p0(1, 0, 4'h0, 8'h10, 32'h0);
    predict();
    @(negedge clk);
    n_checks++;
    if ({p0_rsp_valid, p0_rsp_rdata, mem_read, mem_writeb}
        !== {1'b1, 32'h0, 1'b1, 4'h0}) begin
      n_fail++;
      $display("FAIL wr_ack got %b %h rd %b wb %h", p0_rsp_valid,
               p0_rsp_rdata, mem_read, mem_writeb);
    end
    step();
    set_p0(0, 0, 4'h0, 8'h0, 32'h0);
    predict();
    @(negedge clk);
    n_checks++;
    if ({p0_rsp_valid, p0_rsp_rdata, p1_rsp_valid}
        !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL raw_read got %b %h p1v %b want 1 deadbeef 0",
               p0_rsp_valid, p0_rsp_rdata, p1_rsp_valid);
    end
    step();
  endtask

  task automatic test_partial();
    set_p0(1, 1, 4'hF, 8'h20, 32'h11223344);
    predict(); step();
    set_p0(1, 1, 4'b0010, 8'h20, 32'h0000AB00);
    predict(); step();
    set_p0(1, 0, 4'h0, 8'h20, 32'h0);
    predict(); step();
    set_p0(1, 1, 4'h0, 8'h20, 32'hFFFFFFFF);
    predict();
    @(negedge clk);
    n_checks++;
    if ({p0_rsp_valid, p0_rsp_rdata} !== {1'b1, 32'h1122AB44}) begin
      n_fail++;
      $display("FAIL partial_read got %b %h want 1 1122ab44",
               p0_rsp_valid, p0_rsp_rdata);
    end
    n_checks++;
    if ({p0_ready, mem_writeb, mem_read} !== {1'b1, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL be0_drive got rdy %b wb %h rd %b want 1 0 0",
               p0_ready, mem_writeb, mem_read);
    end
    step();
    set_p0(1, 0, 4'h0, 8'h20, 32'h0);
    predict();
    @(negedge clk);
    n_checks++;
    if ({p0_rsp_valid, p0_rsp_rdata} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL be0_ack got %b %h want 1 0",
               p0_rsp_valid, p0_rsp_rdata);
    end
    step();
    set_p0(0, 0, 4'h0, 8'h0, 32'h0);
    predict();
    @(negedge clk);
    n_checks++;
    if (p0_rsp_rdata !== 32'h1122AB44) begin
      n_fail++;
      $display("FAIL be0_unchanged got %h want 1122ab44",
               p0_rsp_rdata);
    end
    step();
  endtask

  task automatic test_contention();
    bit want1, prev1;
    prev1 = 0;
    rst_n = 1'b0;
    predict(); step();
    rst_n = 1'b1;
    set_p0(1, 0, 4'h0, 8'h10, 32'h0);
    set_p1(1, 0, 4'h0, 8'h20, 32'h0);
    for (int i = 0; i < 20; i++) begin
      predict();
      @(negedge clk);
`ifdef DMEM_ARB_RR_EN
      want1 = (i % 2 == 1);
`else
      want1 = (i % (STARVE_LIMIT + 1) == STARVE_LIMIT);
`endif
      n_checks++;
      if ({p0_ready, p1_ready} !== {!want1, want1}) begin
        n_fail++;
        $display("FAIL contend_grant cyc %0d got %b%b want %b%b",
                 i, p0_ready, p1_ready, !want1, want1);
      end
      if (i > 0) begin
        n_checks++;
        if ({p0_rsp_valid, p1_rsp_valid} !== {!prev1, prev1}) begin
          n_fail++;
          $display("FAIL contend_rsp cyc %0d got %b%b want %b%b",
                   i, p0_rsp_valid, p1_rsp_valid, !prev1, prev1);
        end
      end
      prev1 = want1;
      step();
    end
    set_p0(0, 0, 4'h0, 8'h0, 32'h0);
    set_p1(0, 0, 4'h0, 8'h0, 32'h0);
    predict(); step();
  endtask

  task automatic test_hold();
    bit done;
    int waited;
    done = 0;
    waited = 0;
    set_p0(1, 0, 4'h0, 8'h10, 32'h0);
    set_p1(1, 1, 4'hF, 8'h30, 32'hCAFEF00D);
    for (int i = 0; i < 8 && !done; i++) begin
      predict();
      @(negedge clk);
      done = p1_ready;
      waited = i;
      n_checks++;
      if (mem_addr !== (p1_ready ? 8'h30 : 8'h10)) begin
        n_fail++;
        $display("FAIL hold_addr cyc %0d got %h rdy1 %b",
                 i, mem_addr, p1_ready);
      end
      step();
      if (done) set_p1(0, 0, 4'h0, 8'h0, 32'h0);
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL hold_timeout got no p1 grant in 8 cycles");
    end
`ifndef DMEM_ARB_RR_EN
    n_checks++;
    if (waited != STARVE_LIMIT) begin
      n_fail++;
      $display("FAIL hold_wait got %0d want %0d",
               waited, STARVE_LIMIT);
    end
`endif
    set_p0(0, 0, 4'h0, 8'h0, 32'h0);
    predict();
    @(negedge clk);
    n_checks++;
    if ({p1_rsp_valid, p0_rsp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL hold_ack got p1 %b p0 %b want 1 0",
               p1_rsp_valid, p0_rsp_valid);
    end
    step();
  endtask

  task automatic test_reset_mid();
    set_p0(0, 0, 4'h0, 8'h0, 32'h0);
    set_p1(1, 0, 4'h0, 8'h10, 32'h0);
    predict();
    @(negedge clk);
    n_checks++;
    if (p1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_accept got %b want 1", p1_ready);
    end
    step();
    rst_n = 1'b0;
    predict();
    @(negedge clk);
    n_checks++;
    if ({p1_ready, mem_read, mem_writeb, p1_rsp_valid} !== 7'b0) begin
      n_fail++;
      $display("FAIL rmid_inreset got rdy %b rd %b wb %h rv %b",
               p1_ready, mem_read, mem_writeb, p1_rsp_valid);
    end
    step();
    rst_n = 1'b1;
    predict();
    @(negedge clk);
    n_checks++;
    if ({p1_rsp_valid, p1_ready, mem_read} !== 3'b011) begin
      n_fail++;
      $display("FAIL rmid_resume got rv %b rdy %b rd %b want 0 1 1",
               p1_rsp_valid, p1_ready, mem_read);
    end
    step();
    set_p1(0, 0, 4'h0, 8'h0, 32'h0);
    predict();
    @(negedge clk);
    n_checks++;
    if ({p1_rsp_valid, p1_rsp_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL rmid_data got %b %h want 1 deadbeef",
               p1_rsp_valid, p1_rsp_rdata);
    end
    step();
  endtask

  task automatic test_random();
    bit hold0, hold1;
    for (int i = 0; i < 8; i++) begin
      set_p0(1, 1, 4'hF, 8'(8'h40 + i), $urandom);
      predict(); step();
    end
    set_p0(0, 0, 4'h0, 8'h0, 32'h0);
    predict(); step();
    hold0 = 0;
    hold1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!hold0)
        set_p0($urandom_range(0, 3) != 0, $urandom_range(0, 1),
               4'($urandom), 8'(8'h40 + $urandom_range(0, 7)),
               $urandom);
      if (!hold1)
        set_p1($urandom_range(0, 2) != 0, $urandom_range(0, 1),
               4'($urandom), 8'(8'h40 + $urandom_range(0, 7)),
               $urandom);
      predict();
      @(negedge clk);
      n_checks++;
      if ({p0_ready, p1_ready, mem_writeb, mem_read,
           mem_addr, mem_wdata} !==
          {exp_g0, exp_g1, exp_wb, exp_rd,
           exp_addr, exp_wdata}) begin
        n_fail++;
        $display("FAIL rnd_req cyc %0d got %b%b %h %b %h %h want %b%b %h %b %h %h",
                 i, p0_ready, p1_ready, mem_writeb, mem_read,
                 mem_addr, mem_wdata, exp_g0, exp_g1, exp_wb,
                 exp_rd, exp_addr, exp_wdata);
      end
      n_checks++;
      if ({p0_rsp_valid, p0_rsp_rdata, p1_rsp_valid, p1_rsp_rdata}
          !== {exp_rv0, exp_rd0, exp_rv1, exp_rd1}) begin
        n_fail++;
        $display("FAIL rnd_rsp cyc %0d got %b %h %b %h want %b %h %b %h",
                 i, p0_rsp_valid, p0_rsp_rdata, p1_rsp_valid,
                 p1_rsp_rdata, exp_rv0, exp_rd0, exp_rv1, exp_rd1);
      end
      hold0 = p0_valid && !exp_g0;
      hold1 = p1_valid && !exp_g1;
      step();
    end
    set_p0(0, 0, 4'h0, 8'h0, 32'h0);
    set_p1(0, 0, 4'h0, 8'h0, 32'h0);
    predict(); step();
  endtask

  initial begin
    rst_n = 1'b0;
    set_p0(0, 0, 4'h0, 8'h0, 32'h0);
    set_p1(0, 0, 4'h0, 8'h0, 32'h0);
    m_wait = 0;
    m_pref1 = 0;
    pend_v = 0;
    pend_port = 0;
    pend_data = 32'h0;
    predict();
    step();
    test_reset();
    test_write_read();
    test_partial();
    test_contention();
    test_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
